cpu_run_dbg_ctrl: RTL
=====================

Name: cpu_run_dbg_ctrl

Overview:
CPU-side responder for the PDU control bus and debug bus.
- Gates pipeline advance (cpu_en) from the PDU run request (pdu_run).
- Stops the CPU on a PC breakpoint or a program-end request, and reports the stop to the PDU on cpu_stop.
- Answers debug reads (chk_addr -> chk_data) from status registers, the register file and data memory.
- Sits in the CPU top, between the PDU and the pipeline, register file and data memory debug ports.

Parameters:
DM_DBG_AW, 12, width of the data-memory debug word address (window size 2^DM_DBG_AW words).
RF_AW, 5, register file address width.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
pdu_run  in  1  PDU run request, level; a rising edge starts a run
pdu_breakpoint  in  32  breakpoint PC; 0 = disabled
cpu_stop  out  1  CPU stopped (breakpoint or program end), level
cpu_en  out  1  pipeline advance enable
current_pc  in  32  fetch-stage PC
commit_valid  in  1  an instruction retires this cycle (qualified by cpu_en)
halt_req  in  1  program end (ebreak/ecall-exit) detected at commit
chk_addr  in  16  debug read address
chk_data  out  32  debug read data
rf_dbg_addr  out  RF_AW  register file debug read address
rf_dbg_rdata  in  32  register file debug data, valid one cycle after address
dm_dbg_addr  out  DM_DBG_AW  data-memory debug word address
dm_dbg_rdata  in  32  data-memory debug data, valid one cycle after address

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, cpu_en=0, cpu_stop=0.
  - cause=0, armed=0, run_q=0.
  - cycle_cnt=0, instret=0, chk_data=0.
  - rf_dbg_addr=0, dm_dbg_addr=0.
- run_q registers pdu_run. start = pdu_run & ~run_q.
- States:
  - IDLE: cpu_en=0, cpu_stop=0. start -> RUN; armed<=0.
  - RUN: cpu_en=1 combinationally unless the stop conditions below fire in that cycle.
    - ~pdu_run -> IDLE, cpu_stop stays 0 (PDU left run for its own reasons).
    - halt_req & cpu_en -> HALT_STOP, cause=2. The halting instruction still retires.
    - armed & pdu_breakpoint!=0 & current_pc==pdu_breakpoint -> BP_STOP, cause=1. cpu_en=0 in that same cycle, so the instruction at the breakpoint is not executed.
    - armed<=1 on the first RUN cycle where current_pc != pdu_breakpoint. This makes "continue" from a breakpoint PC (PDU reloads the breakpoint with the current PC) step past it.
    - Priority: ~pdu_run > halt_req > breakpoint.
  - BP_STOP / HALT_STOP: cpu_en=0, cpu_stop=1 (registered; asserted the cycle after entry).
    - start -> RUN; cpu_stop<=0, armed<=0.
    - pdu_run held high keeps the state; no restart without a new rising edge.
- Counters (32-bit, wrap 0xFFFFFFFF -> 0):
  - cycle_cnt increments each cycle cpu_en=1.
  - instret increments when commit_valid & cpu_en.
- Debug read path, fixed 2-cycle latency from a chk_addr change to the chk_data update:
  - Cycle 1: register chk_addr into addr_q. rf_dbg_addr<=chk_addr[RF_AW-1:0]; dm_dbg_addr<=chk_addr[DM_DBG_AW-1:0].
  - Cycle 2: chk_data <= mux(addr_q), with this map:
    - 0x0000 current_pc
    - 0x0001 {27'b0, state[2:0], cause[1:0]}, with state encoding IDLE=0, RUN=1, BP_STOP=2, HALT_STOP=3
    - 0x0002 cycle_cnt
    - 0x0003 instret
    - 0x0004 pdu_breakpoint
    - 0x1000–0x101F rf_dbg_rdata
    - 0x2000–0x2FFF dm_dbg_rdata (DM_DBG_AW=12)
    - anything else 0
  - Reads work in every state, including RUN, and have no side effects.
- halt_req while not in RUN is ignored.
- pdu_breakpoint changes take effect the same cycle. Clearing pdu_breakpoint to 0 disables the breakpoint immediately.
- Reset mid-run: immediate IDLE, counters cleared, cpu_en=0 asynchronously.

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - state encoding (IDLE, RUN, BP_STOP, HALT_STOP)
  - cause codes (NONE=0, BP=1, HALT=2)
  - debug address map constants (DBG_PC, DBG_STATUS, DBG_CYCLE, DBG_INSTRET, DBG_BP, DBG_RF_BASE, DBG_DM_BASE)
- One natural sub-module: cpu_dbg_readmux, the registered address decode plus data mux (cycle 1/2 pipeline).
- The run FSM and the counters stay in the top.

Test Plan:
- Reset, then pdu_run 0->1 with pdu_breakpoint=0 -> cpu_en=1 from the cycle after the edge; cpu_stop=0; cycle_cnt counts 1,2,3...
- pdu_breakpoint=0x00000010, PC sequence 0x0,0x4,...,0x10 -> cpu_en=0 in the cycle current_pc=0x10; cpu_stop=1 next cycle; 0x0001 reads cause=1, state=2.
- From BP_STOP at 0x10, pdu_breakpoint=0x10, pdu_run low then high -> cpu_stop=0, cpu_en=1, PC advances to 0x14 without re-stopping; a later return to 0x10 stops again.
- halt_req with commit_valid in RUN -> instret increments for that instruction; next state HALT_STOP; cpu_stop=1; pdu_run staying high does not restart.
- chk_addr=0x1005 with rf_dbg_rdata=0xDEADBEEF for x5 -> rf_dbg_addr=5 after 1 cycle; chk_data=0xDEADBEEF after 2 cycles. chk_addr=0x2003 -> dm_dbg_addr=3. chk_addr=0x0FFF -> chk_data=0.
- Counter wrap: force instret to 0xFFFFFFFF, retire one instruction -> 0x00000000. Assert rstn=0 mid-RUN -> cpu_en=0 immediately; all counters 0.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU run/debug controller: run states, stop causes,
// debug address map and small decode helpers.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_BP_STOP   = 3'd2,
    ST_HALT_STOP = 3'd3
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_BP   = 2'd1,
    CAUSE_HALT = 2'd2
  } stop_cause_e;

  localparam logic [15:0] DBG_PC      = 16'h0000;
  localparam logic [15:0] DBG_STATUS  = 16'h0001;
  localparam logic [15:0] DBG_CYCLE   = 16'h0002;
  localparam logic [15:0] DBG_INSTRET = 16'h0003;
  localparam logic [15:0] DBG_BP      = 16'h0004;
  localparam logic [15:0] DBG_RF_BASE = 16'h1000;
  localparam logic [15:0] DBG_DM_BASE = 16'h2000;

  // Status register layout seen by the PDU.
  function automatic logic [31:0] status_word(run_state_e st, stop_cause_e cause);
    return {27'd0, st, cause};
  endfunction

  // True when addr falls in the 2^aw-entry window starting at base (base aligned).
  function automatic logic in_window(logic [15:0] addr, logic [15:0] base, int unsigned aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/cpu_dbg_readmux.sv
// Debug read path: stage 1 registers the address and drives the RF/DM debug
// ports, stage 2 selects the answer once the memories have responded.
module cpu_dbg_readmux
  import cpu_dbg_pkg::*;
#(
  parameter int DM_DBG_AW = 12,
  parameter int RF_AW     = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [15:0]          chk_addr,
  input  logic [31:0]          current_pc,
  input  logic [31:0]          status,
  input  logic [31:0]          cycle_cnt,
  input  logic [31:0]          instret,
  input  logic [31:0]          pdu_breakpoint,
  input  logic [31:0]          rf_dbg_rdata,
  input  logic [31:0]          dm_dbg_rdata,
  output logic [RF_AW-1:0]     rf_dbg_addr,
  output logic [DM_DBG_AW-1:0] dm_dbg_addr,
  output logic [31:0]          chk_data
);

  logic [15:0]          addr_q_r;
  logic [RF_AW-1:0]     rf_dbg_addr_r;
  logic [DM_DBG_AW-1:0] dm_dbg_addr_r;
  logic [31:0]          chk_data_r;
  logic [31:0]          mux_s;

  // Stage 1: capture the requested address and present it to RF/DM debug ports.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q_r      <= 16'd0;
      rf_dbg_addr_r <= '0;
      dm_dbg_addr_r <= '0;
    end else begin
      addr_q_r      <= chk_addr;
      rf_dbg_addr_r <= chk_addr[RF_AW-1:0];
      dm_dbg_addr_r <= chk_addr[DM_DBG_AW-1:0];
    end
  end

  // Address decode for the registered address; unmapped reads return zero.
  always_comb begin
    mux_s = 32'd0;
    if (in_window(addr_q_r, DBG_RF_BASE, RF_AW)) begin
      mux_s = rf_dbg_rdata;
    end else if (in_window(addr_q_r, DBG_DM_BASE, DM_DBG_AW)) begin
      mux_s = dm_dbg_rdata;
    end else begin
      case (addr_q_r)
        DBG_PC:      mux_s = current_pc;
        DBG_STATUS:  mux_s = status;
        DBG_CYCLE:   mux_s = cycle_cnt;
        DBG_INSTRET: mux_s = instret;
        DBG_BP:      mux_s = pdu_breakpoint;
        default:     mux_s = 32'd0;
      endcase
    end
  end

  // Stage 2: register the selected read data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chk_data_r <= 32'd0;
    end else begin
      chk_data_r <= mux_s;
    end
  end

  assign rf_dbg_addr = rf_dbg_addr_r;
  assign dm_dbg_addr = dm_dbg_addr_r;
  assign chk_data    = chk_data_r;

endmodule

// File: rtl/cpu_run_dbg_ctrl.sv
// CPU-side run/stop controller: gates the pipeline from the PDU run request,
// stops on breakpoint or program end, keeps cycle/instret counters and
// answers debug reads.
module cpu_run_dbg_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int DM_DBG_AW = 12,
  parameter int RF_AW     = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pdu_run,
  input  logic [31:0]          pdu_breakpoint,
  output logic                 cpu_stop,
  output logic                 cpu_en,
  input  logic [31:0]          current_pc,
  input  logic                 commit_valid,
  input  logic                 halt_req,
  input  logic [15:0]          chk_addr,
  output logic [31:0]          chk_data,
  output logic [RF_AW-1:0]     rf_dbg_addr,
  input  logic [31:0]          rf_dbg_rdata,
  output logic [DM_DBG_AW-1:0] dm_dbg_addr,
  input  logic [31:0]          dm_dbg_rdata
);

  run_state_e  state_r, state_s;
  stop_cause_e cause_r, cause_s;
  logic        armed_r;
  logic        run_q_r;
  logic        cpu_stop_r;
  logic [31:0] cycle_cnt_r;
  logic [31:0] instret_r;
  logic        start_s;
  logic        bp_hit_s;
  logic        cpu_en_s;
  logic [31:0] status_s;

  assign start_s  = pdu_run & ~run_q_r;
  assign bp_hit_s = armed_r & (pdu_breakpoint != 32'd0) & (current_pc == pdu_breakpoint);

  // Next state and pipeline enable; halt outranks breakpoint so the halting
  // instruction still retires, while a breakpoint blocks its own instruction.
  always_comb begin
    state_s  = state_r;
    cause_s  = cause_r;
    cpu_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_RUN;
        else         state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!pdu_run) begin
          state_s = ST_IDLE;
        end else if (halt_req) begin
          cpu_en_s = 1'b1;
          state_s  = ST_HALT_STOP;
          cause_s  = CAUSE_HALT;
        end else if (bp_hit_s) begin
          state_s = ST_BP_STOP;
          cause_s = CAUSE_BP;
        end else begin
          cpu_en_s = 1'b1;
        end
      end
      ST_BP_STOP, ST_HALT_STOP: begin
        if (start_s) state_s = ST_RUN;
        else         state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, cause, run-edge history and stop flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      cause_r    <= CAUSE_NONE;
      run_q_r    <= 1'b0;
      cpu_stop_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cause_r    <= cause_s;
      run_q_r    <= pdu_run;
      cpu_stop_r <= (state_s == ST_BP_STOP) || (state_s == ST_HALT_STOP);
    end
  end

  // Breakpoint arming: cleared on every (re)start, set once the PC has left
  // the breakpoint address so a resume from the breakpoint steps past it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed_r <= 1'b0;
    end else if (state_r == ST_RUN) begin
      if (current_pc != pdu_breakpoint) armed_r <= 1'b1;
    end else if (start_s) begin
      armed_r <= 1'b0;
    end
  end

  // Free-running performance counters, advancing only while the pipeline runs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt_r <= 32'd0;
      instret_r   <= 32'd0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + {31'd0, cpu_en_s};
      instret_r   <= instret_r + {31'd0, commit_valid & cpu_en_s};
    end
  end

  assign status_s = status_word(state_r, cause_r);
  assign cpu_en   = cpu_en_s;
  assign cpu_stop = cpu_stop_r;

  cpu_dbg_readmux #(
    .DM_DBG_AW (DM_DBG_AW),
    .RF_AW     (RF_AW)
  ) u_readmux (
    .clk            (clk),
    .rstn           (rstn),
    .chk_addr       (chk_addr),
    .current_pc     (current_pc),
    .status         (status_s),
    .cycle_cnt      (cycle_cnt_r),
    .instret        (instret_r),
    .pdu_breakpoint (pdu_breakpoint),
    .rf_dbg_rdata   (rf_dbg_rdata),
    .dm_dbg_rdata   (dm_dbg_rdata),
    .rf_dbg_addr    (rf_dbg_addr),
    .dm_dbg_addr    (dm_dbg_addr),
    .chk_data       (chk_data)
  );

endmodule
